// File: rtl/count_rate_sched.sv
// count_rate_sched
//   Run/pause/clear controller for the 4-bit display counter. A single shared
//   prescaler produces the tick rate that rate_sel picks. A 4-state FSM
//   (IDLE/RUN/PAUSE/DONE) decides when the counter advances.
//
// Optional feature: define AUTO_RELOAD_EN to make the terminal tick wrap the
//   count back to 0 with a one-cycle wrap pulse and stay in RUN. With it
//   undefined, the terminal tick enters DONE and wrap is tied to 0.
//
// Ports
//   CLOCK_50  in   system clock, rising edge
//   resetn    in   asynchronous active-low reset
//   rate_sel  in   tick period: 00=2 clk, 01=BASE_DIV, 10=2*BASE_DIV, 11=4*BASE_DIV
//   start     in   1-cycle strobe: run / resume / restart from DONE
//   stop      in   1-cycle strobe: pause (RUN only)
//   clear     in   1-cycle strobe: back to IDLE with count=0
//   count     out  current count
//   tick      out  1-cycle pulse following each prescaler-driven count change
//   running   out  state is RUN
//   done      out  state is DONE
//   state     out  IDLE=00 RUN=01 PAUSE=10 DONE=11
//   wrap      out  1-cycle rollover pulse (AUTO_RELOAD_EN only, else 0)

module count_rate_sched #(
    parameter int BASE_DIV = 50000000,
    parameter int PRE_W    = 28,
    parameter int CNT_W    = 4,
    parameter int TERMINAL = 15
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [1:0]       rate_sel,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             running,
    output logic             done,
    output logic [1:0]       state,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [PRE_W-1:0] DM1_FAST = PRE_W'(1);
    localparam logic [PRE_W-1:0] DM1_X1   = PRE_W'(BASE_DIV - 1);
    localparam logic [PRE_W-1:0] DM1_X2   = PRE_W'(2 * BASE_DIV - 1);
    localparam logic [PRE_W-1:0] DM1_X4   = PRE_W'(4 * BASE_DIV - 1);
    localparam logic [CNT_W-1:0] TERM     = CNT_W'(TERMINAL);

    state_t             state_q, state_nxt;
    logic [PRE_W-1:0]   pre, pre_nxt, div_m1;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [1:0]         rate_q, rate_nxt;
    logic               tick_nxt;
    logic               rate_chg;
`ifdef AUTO_RELOAD_EN
    logic               wrap_q, wrap_nxt;
`endif

    // Terminal prescaler value for the registered rate.
    always_comb begin
        case (rate_q)
            2'b00:   div_m1 = DM1_FAST;
            2'b01:   div_m1 = DM1_X1;
            2'b10:   div_m1 = DM1_X2;
            default: div_m1 = DM1_X4;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        pre_nxt   = pre;
        cnt_nxt   = count;
        tick_nxt  = 1'b0;
        rate_nxt  = rate_q;
`ifdef AUTO_RELOAD_EN
        wrap_nxt  = 1'b0;
`endif
        rate_chg  = (rate_sel != rate_q);

        // Strobes that mean nothing in a state are dropped before priority
        // is applied, so e.g. stop+start in PAUSE still resumes.
        case (state_q)
            S_IDLE: begin
                pre_nxt = '0;
                cnt_nxt = '0;
                if (!clear && start) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                    pre_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (stop) begin
                    // prescaler holds, so a resume finishes the current period
                    state_nxt = S_PAUSE;
                end else if (!rate_chg) begin
                    if (pre == div_m1) begin
                        pre_nxt = '0;
                        if (count == TERM) begin
`ifdef AUTO_RELOAD_EN
                            cnt_nxt  = '0;
                            tick_nxt = 1'b1;
                            wrap_nxt = 1'b1;
`else
                            state_nxt = S_DONE;
`endif
                        end else begin
                            cnt_nxt  = count + 1'b1;
                            tick_nxt = 1'b1;
                        end
                    end else begin
                        pre_nxt = pre + 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                    pre_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                    pre_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (start) begin
                    state_nxt = S_RUN;
                    pre_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // A rate change restarts the period in every state and swallows
        // any tick that would have landed this cycle.
        if (rate_chg) begin
            rate_nxt = rate_sel;
            pre_nxt  = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            pre     <= '0;
            count   <= '0;
            rate_q  <= 2'b00;
            tick    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
`ifdef AUTO_RELOAD_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            pre     <= pre_nxt;
            count   <= cnt_nxt;
            rate_q  <= rate_nxt;
            tick    <= tick_nxt;
            running <= (state_nxt == S_RUN);
            done    <= (state_nxt == S_DONE);
`ifdef AUTO_RELOAD_EN
            wrap_q  <= wrap_nxt;
`endif
        end
    end

    assign state = state_q;
`ifdef AUTO_RELOAD_EN
    assign wrap  = wrap_q;
`else
    assign wrap  = 1'b0;
`endif

endmodule

// File: tb/tb_count_rate_sched.sv
// tb_count_rate_sched
//   Self-checking bench for count_rate_sched with BASE_DIV=10. Directed
//   scenarios (reset, rates, terminal, pause, rate change, priority) are
//   followed by random strobes and rate changes. Every cycle is compared
//   against a behavioural model.

module tb_count_rate_sched;

    localparam int BASE_DIV = 10;
    localparam int TERMINAL = 15;

    logic       CLOCK_50;
    logic       resetn;
    logic [1:0] rate_sel;
    logic       start, stop, clear;
    logic [3:0] count;
    logic       tick, running, done, wrap;
    logic [1:0] state;

    count_rate_sched #(
        .BASE_DIV (BASE_DIV),
        .PRE_W    (28),
        .CNT_W    (4),
        .TERMINAL (TERMINAL)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .rate_sel (rate_sel),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .count    (count),
        .tick     (tick),
        .running  (running),
        .done     (done),
        .state    (state),
        .wrap     (wrap)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0;
    int n_err = 0;

    // model: 0=IDLE 1=RUN 2=PAUSE 3=DONE; m_pre = cycles elapsed in the period
    int m_state, m_pre, m_cnt, m_rate;
    bit m_tick, m_wrap;

    wire [11:0] obs = {state, running, done, tick, wrap, count};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] mexp();
        return {2'(m_state), m_state == 1, m_state == 3, m_tick, m_wrap, 4'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_cnt = 0; m_rate = 0; m_tick = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit cl, input int rs);
        bit rchg;
        int period;
        rchg   = (rs != m_rate);
        period = (m_rate == 0) ? 2 : (BASE_DIV << (m_rate - 1));
        m_tick = 0;
        m_wrap = 0;
        case (m_state)
            0: if (!cl && st) m_state = 1;
            1: begin
                if (cl) begin
                    m_state = 0; m_cnt = 0; m_pre = 0;
                end else if (sp) begin
                    m_state = 2;
                end else if (!rchg) begin
                    m_pre++;
                    if (m_pre == period) begin
                        m_pre = 0;
                        if (m_cnt == TERMINAL) begin
`ifdef AUTO_RELOAD_EN
                            m_cnt = 0; m_tick = 1; m_wrap = 1;
`else
                            m_state = 3;
`endif
                        end else begin
                            m_cnt  = (m_cnt + 1) % 16;
                            m_tick = 1;
                        end
                    end
                end
            end
            2: begin
                if (cl) begin
                    m_state = 0; m_cnt = 0; m_pre = 0;
                end else if (st) begin
                    m_state = 1;
                end
            end
            3: begin
                if (cl) begin
                    m_state = 0; m_cnt = 0; m_pre = 0;
                end else if (st) begin
                    m_state = 1; m_cnt = 0; m_pre = 0;
                end
            end
            default: m_state = 0;
        endcase
        if (rchg) begin
            m_rate = rs;
            m_pre  = 0;
        end
    endtask

    // One clock: inputs are already set; returns at the following negedge.
    task automatic cycle();
        @(posedge CLOCK_50);
        model_step(start, stop, clear, int'(rate_sel));
        #1;
        chk("cyc", 32'(obs), 32'(mexp()));
        @(negedge CLOCK_50);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic strobe(input bit st, input bit sp, input bit cl);
        start = st; stop = sp; clear = cl;
        cycle();
        start = 0; stop = 0; clear = 0;
    endtask

    // Reset dropped between edges; outputs must clear without waiting for a clock.
    task automatic mid_reset(input string tag);
        #2 resetn = 1'b0;
        #1 chk(tag, 32'(obs), 32'h0);
        model_reset();
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; rate_sel = 2'b00; start = 0; stop = 0; clear = 0;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        chk("rst_outs", 32'(obs), 32'h0);
        resetn = 1'b1;
        cycles(3);
        chk("rst_idle", 32'(state), 32'h0);

        // T2: rate 01, ticks every 10 cycles after the start edge
        rate_sel = 2'b01;
        cycle();
        strobe(1, 0, 0);
        cycles(9);
        chk("t2_pre_tick", 32'(count), 32'd0);
        cycle();
        chk("t2_cnt1", 32'(count), 32'd1);
        chk("t2_tick1", 32'(tick), 32'd1);
        cycle();
        chk("t2_tick_lo", 32'(tick), 32'd0);
        cycles(9);
        chk("t2_cnt2", 32'(count), 32'd2);
        chk("t2_tick2", 32'(tick), 32'd1);

        // T3: run fast to the terminal count
        rate_sel = 2'b00;
`ifdef AUTO_RELOAD_EN
        for (int i = 0; i < 100 && wrap !== 1'b1; i++) cycle();
        chk("t3_wrap", 32'(wrap), 32'd1);
        chk("t3_wrap_cnt", 32'(count), 32'd0);
        chk("t3_wrap_state", 32'(state), 32'd1);
        chk("t3_wrap_tick", 32'(tick), 32'd1);
        cycle();
        chk("t3_wrap_lo", 32'(wrap), 32'd0);
        chk("t3_still_run", 32'(state), 32'd1);
`else
        for (int i = 0; i < 100 && state !== 2'b11; i++) cycle();
        chk("t3_done_state", 32'(state), 32'd3);
        chk("t3_done_flag", 32'(done), 32'd1);
        chk("t3_done_cnt", 32'(count), 32'd15);
        chk("t3_done_tick", 32'(tick), 32'd0);
        cycles(5);
        chk("t3_done_hold", 32'(count), 32'd15);
        strobe(1, 0, 0);
        chk("t3_restart_cnt", 32'(count), 32'd0);
        chk("t3_restart_run", 32'(running), 32'd1);
`endif

        // T4: pause at prescaler 4, resume finishes the period in 6 cycles
        rate_sel = 2'b01;
        strobe(0, 0, 1);
        chk("t4_clear", 32'(state), 32'd0);
        strobe(1, 0, 0);
        cycles(4);
        strobe(0, 1, 0);
        chk("t4_paused", 32'(state), 32'd2);
        cycles(100);
        chk("t4_frozen", 32'(count), 32'd0);
        strobe(1, 0, 0);
        cycles(5);
        chk("t4_no_tick_yet", 32'(count), 32'd0);
        cycle();
        chk("t4_resume_tick", 32'(tick), 32'd1);
        chk("t4_resume_cnt", 32'(count), 32'd1);

        // T5: switch to 4*BASE_DIV at prescaler 7
        cycles(7);
        rate_sel = 2'b11;
        cycle();
        cycles(39);
        chk("t5_no_tick", 32'(count), 32'd1);
        cycle();
        chk("t5_tick", 32'(count), 32'd2);
        chk("t5_tick_pulse", 32'(tick), 32'd1);

        // T6: clear wins over stop and start
        strobe(1, 1, 1);
        chk("t6_all_state", 32'(state), 32'd0);
        chk("t6_all_cnt", 32'(count), 32'd0);
        // stop on the terminal edge beats the increment
        rate_sel = 2'b01;
        cycle();
        strobe(1, 0, 0);
        cycles(9);
        strobe(0, 1, 0);
        chk("t6_stop_state", 32'(state), 32'd2);
        chk("t6_stop_cnt", 32'(count), 32'd0);
        chk("t6_stop_tick", 32'(tick), 32'd0);
        strobe(1, 0, 0);
        cycle();
        chk("t6_held_term", 32'(count), 32'd1);

        // T1: asynchronous reset while running
        cycles(3);
        mid_reset("t1_async");
        cycles(4);
        chk("t1_after", 32'(obs), 32'h0);

        // random strobes, rate changes and the odd reset
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            clear = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 149) == 0)
                rate_sel = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) mid_reset("rnd_reset");
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
